// File: rtl/mcp_pkg.sv
// Shared encodings for the multicycle MIPS main control sequencer.
// MCP_BNE_EN: when defined, bne (000101) is a legal branch on ~Zero.
package mcp_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

  // Opcodes that DECODE dispatches; everything else is an illegal NOP.
  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MCP_BNE_EN
    ok = ok || (op == OP_BNE);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mcp_ctrl_outdec.sv
// State to control-word decoder for the multicycle MIPS sequencer.
// Purely combinational; unused encodings decode to all-zero.
module mcp_ctrl_outdec
  import mcp_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  output ctrl_t              ctrl_o
);

  // Moore output table: one control word per state.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.irwrite = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcp_main_ctrl.sv
// Main control FSM of the multicycle MIPS core (Moore, sync reset).
// MCP_BNE_EN: when defined, bne branches through BRANCH on ~Zero.
module mcp_main_ctrl
  import mcp_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] STATE
);

  logic [STATE_W-1:0] state_q;
  ctrl_t              ctrl;
  logic               run;
  logic               br_cond;

  // State register and transitions; Opcode is read in DECODE/MEMADR only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:   state_q <= S_DECODE;
        S_DECODE: begin
          if (Opcode == OP_LW || Opcode == OP_SW)
            state_q <= S_MEMADR;
          else if (Opcode == OP_RTYPE)
            state_q <= S_EXECUTE;
          else if (Opcode == OP_BEQ)
            state_q <= S_BRANCH;
`ifdef MCP_BNE_EN
          else if (Opcode == OP_BNE)
            state_q <= S_BRANCH;
`endif
          else if (Opcode == OP_ADDI)
            state_q <= S_ADDIEX;
          else if (Opcode == OP_J)
            state_q <= S_JUMP;
          else
            state_q <= S_FETCH;
        end
        S_MEMADR:
          state_q <= (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state_q <= S_MEMWB;
        S_EXECUTE: state_q <= S_ALUWB;
        S_ADDIEX:  state_q <= S_ADDIWB;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  mcp_ctrl_outdec #(
    .STATE_W (STATE_W)
  ) u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Branch condition: Zero for beq, inverted for bne when enabled.
  always_comb begin
`ifdef MCP_BNE_EN
    br_cond = (Opcode == OP_BNE) ? ~Zero : Zero;
`else
    br_cond = Zero;
`endif
  end

  // Reset forces every output low so no partial write can occur.
  assign run       = ~RST;
  assign IorD      = run & ctrl.iord;
  assign MemWrite  = run & ctrl.memwrite;
  assign IRWrite   = run & ctrl.irwrite;
  assign RegDst    = run & ctrl.regdst;
  assign MemtoReg  = run & ctrl.memtoreg;
  assign RegWrite  = run & ctrl.regwrite;
  assign ALUSrcA   = run & ctrl.alusrca;
  assign ALUSrcB   = {2{run}} & ctrl.alusrcb;
  assign ALUOp     = {2{run}} & ctrl.aluop;
  assign PCSrc     = {2{run}} & ctrl.pcsrc;
  assign PCEn      = run & (ctrl.pcwrite | (ctrl.branch & br_cond));
  assign IllegalOp = run & (state_q == S_DECODE) & ~op_legal(Opcode);
  assign STATE     = {STATE_W{run}} & state_q;

endmodule

// File: tb/tb_mcp_main_ctrl.sv
// Scoreboard bench for mcp_main_ctrl: per-cycle expected words are
// queued when an instruction is issued and popped each cycle.
module tb_mcp_main_ctrl;
  import mcp_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] Opcode;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCEn, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] STATE;

  mcp_main_ctrl #(.STATE_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .IllegalOp (IllegalOp),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  logic [18:0] obs_w;
  assign obs_w = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp, STATE};

  logic [18:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [18:0] got,
                     input logic [18:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] exp_word(input logic [3:0] s,
                                           input logic [5:0] op,
                                           input logic z);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, ill, legal;
    logic [1:0] sb, aop, pcs;
    {iord, mw, irw, rd, m2r, rw, sa, pcen, ill} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    legal = (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000000) || (op == 6'b000100) ||
            (op == 6'b001000) || (op == 6'b000010);
`ifdef MCP_BNE_EN
    legal = legal || (op == 6'b000101);
`endif
    case (s)
      S_FETCH:   begin irw = 1; sb = 2'b01; pcen = 1; end
      S_DECODE:  begin sb = 2'b11; ill = ~legal; end
      S_MEMADR:  begin sa = 1; sb = 2'b10; end
      S_ADDIEX:  begin sa = 1; sb = 2'b10; end
      S_MEMRD:   iord = 1;
      S_MEMWB:   begin rw = 1; m2r = 1; end
      S_MEMWR:   begin iord = 1; mw = 1; end
      S_EXECUTE: begin sa = 1; aop = 2'b10; end
      S_ALUWB:   begin rd = 1; rw = 1; end
      S_ADDIWB:  rw = 1;
      S_BRANCH: begin
        sa = 1; aop = 2'b01; pcs = 2'b01;
        pcen = (op == 6'b000101) ? ~z : z;
      end
      S_JUMP:    begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {iord, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, pcen, ill, s};
  endfunction

  // Compare one cycle at the falling edge, then move past the next rise.
  task automatic step(input string tag);
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      chk(tag, obs_w, exp_q.pop_front());
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic int push_instr(input logic [5:0] op, input logic z,
                                    input int upto);
    logic [3:0] seq[$];
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (op)
      6'b100011: begin
        seq.push_back(S_MEMADR); seq.push_back(S_MEMRD);
        seq.push_back(S_MEMWB);
      end
      6'b101011: begin
        seq.push_back(S_MEMADR); seq.push_back(S_MEMWR);
      end
      6'b000000: begin
        seq.push_back(S_EXECUTE); seq.push_back(S_ALUWB);
      end
      6'b001000: begin
        seq.push_back(S_ADDIEX); seq.push_back(S_ADDIWB);
      end
      6'b000100: seq.push_back(S_BRANCH);
      6'b000010: seq.push_back(S_JUMP);
`ifdef MCP_BNE_EN
      6'b000101: seq.push_back(S_BRANCH);
`endif
      default: ;
    endcase
    if (upto > 0 && upto < seq.size())
      seq = seq[0:upto-1];
    foreach (seq[i]) exp_q.push_back(exp_word(seq[i], op, z));
    return seq.size();
  endfunction

  task automatic run(input string tag, input logic [5:0] op,
                     input logic z, input int ncyc);
    int n;
    Opcode = op;
    Zero   = z;
    n = push_instr(op, z, 0);
    chk({tag, "_len"}, 19'(n), 19'(ncyc));
    repeat (n) step(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b1;
    Opcode = 6'b000000;
    Zero = 1'b0;
    @(posedge CLK);
    #1;
    exp_q.push_back(19'd0);
    step("rst0");
    exp_q.push_back(19'd0);
    step("rst1");
    RST = 1'b0;

    run("lw",      6'b100011, 1'b0, 5);
    run("beq_z1",  6'b000100, 1'b1, 3);
    run("beq_z0",  6'b000100, 1'b0, 3);
    run("rtype",   6'b000000, 1'b0, 4);
    run("addi",    6'b001000, 1'b1, 4);
    run("j",       6'b000010, 1'b0, 3);
    run("illegal", 6'b111111, 1'b0, 2);
    run("sw",      6'b101011, 1'b0, 4);
`ifdef MCP_BNE_EN
    run("bne_z0",  6'b000101, 1'b0, 3);
    run("bne_z1",  6'b000101, 1'b1, 3);
`else
    run("bne_ill", 6'b000101, 1'b0, 2);
`endif

    Opcode = 6'b101011;
    Zero = 1'b0;
    n = push_instr(6'b101011, 1'b0, 3);
    repeat (n) step("sw_pre");
    RST = 1'b1;
    exp_q.push_back(19'd0);
    step("sw_rst");
    RST = 1'b0;
    run("j_after", 6'b000010, 1'b1, 3);
    run("lw2",     6'b100011, 1'b1, 5);

    chk("sb_drain", 19'(exp_q.size()), 19'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
